// File: rtl/control_sequencer_pkg.sv
// control_sequencer_pkg
//   Shared definitions for the SAP-1 controller-sequencer: widths, control
//   word bit indices, opcodes, T-state one-hot encodings, fetch/execute
//   control words and a one-hot helper function.
package control_sequencer_pkg;

  localparam int CW_WIDTH = 12;  // control word width, fixed by the bit map
  localparam int OP_WIDTH = 4;   // opcode width (IR[7:4])
  localparam int T_COUNT  = 6;   // ring length

  // Control word bit indices (all active-high)
  localparam int CW_INC_PC = 11;
  localparam int CW_EN_PC  = 10;
  localparam int CW_LD_MAR = 9;
  localparam int CW_EN_MEM = 8;
  localparam int CW_LD_IR  = 7;
  localparam int CW_EN_IR  = 6;
  localparam int CW_LD_AR  = 5;
  localparam int CW_EN_AR  = 4;
  localparam int CW_SUB    = 3;
  localparam int CW_EN_ALU = 2;
  localparam int CW_LD_BR  = 1;
  localparam int CW_LD_OUT = 0;

  typedef logic [CW_WIDTH-1:0] cw_t;
  typedef logic [OP_WIDTH-1:0] opcode_t;
  typedef logic [T_COUNT-1:0]  t_vec_t;

  // Opcodes; anything else decodes as NOP
  localparam opcode_t OP_LDA = 4'b0000;
  localparam opcode_t OP_ADD = 4'b0001;
  localparam opcode_t OP_SUB = 4'b0010;
  localparam opcode_t OP_OUT = 4'b1110;
  localparam opcode_t OP_HLT = 4'b1111;

  // One-hot T-states, bit 0 = T1
  typedef enum logic [T_COUNT-1:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } t_state_e;

  // Fetch words, opcode independent
  localparam cw_t CW_NONE     = 12'h000;
  localparam cw_t CW_FETCH_T1 = 12'h600;  // EN_PC | LD_MAR
  localparam cw_t CW_FETCH_T2 = 12'h800;  // INC_PC
  localparam cw_t CW_FETCH_T3 = 12'h180;  // EN_MEM | LD_IR

  // Execute words
  localparam cw_t CW_IR_TO_MAR = 12'h240;  // EN_IR | LD_MAR      (LDA/ADD/SUB T4)
  localparam cw_t CW_MEM_TO_AR = 12'h120;  // EN_MEM | LD_AR      (LDA T5)
  localparam cw_t CW_MEM_TO_BR = 12'h102;  // EN_MEM | LD_BR      (ADD/SUB T5)
  localparam cw_t CW_ALU_ADD   = 12'h024;  // LD_AR | EN_ALU      (ADD T6)
  localparam cw_t CW_ALU_SUB   = 12'h02C;  // LD_AR | SUB | EN_ALU (SUB T6)
  localparam cw_t CW_AR_TO_OUT = 12'h011;  // EN_AR | LD_OUT      (OUT T4)

  // True when exactly one bit of v is set
  function automatic logic is_one_hot(input t_vec_t v);
    return (v != 6'd0) && ((v & (v - 6'd1)) == 6'd0);
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if
//   Control bus between the sequencer and the rest of the SAP-1 machine.
//   opcode       : IR[7:4], driven by the instruction register side
//   control_word : 12-bit strobe/enable word consumed by the datapath
//   t_state      : one-hot T-state, bit 0 = T1
//   halt         : machine halted until reset
//   master = sequencer, slave = IR/datapath side.
interface control_sequencer_if;
  import control_sequencer_pkg::*;

  opcode_t opcode;
  cw_t     control_word;
  t_vec_t  t_state;
  logic    halt;

  modport master (
    input  opcode,
    output control_word,
    output t_state,
    output halt
  );

  modport slave (
    output opcode,
    input  control_word,
    input  t_state,
    input  halt
  );

endinterface

// File: rtl/control_sequencer_chk.sv
// control_sequencer_chk
//   Invariant checker for control_sequencer outputs.
//   clk, rst     : same clock/reset as the sequencer
//   control_word : sequencer control word
//   t_state      : sequencer ring state
//   Checks: single bus driver, one-hot ring, SUB only with EN_ALU.
module control_sequencer_chk
  import control_sequencer_pkg::*;
(
  input logic   clk,
  input logic   rst,
  input cw_t    control_word,
  input t_vec_t t_state
);

  logic [4:0] bus_en_s;

  assign bus_en_s = {control_word[CW_EN_PC], control_word[CW_EN_MEM],
                     control_word[CW_EN_IR], control_word[CW_EN_AR],
                     control_word[CW_EN_ALU]};

  a_single_bus_driver: assert property (@(posedge clk) disable iff (rst)
    $onehot0(bus_en_s));

  a_ring_one_hot: assert property (@(posedge clk) disable iff (rst)
    $onehot(t_state));

  a_sub_needs_alu: assert property (@(posedge clk) disable iff (rst)
    control_word[CW_SUB] |-> control_word[CW_EN_ALU]);

endmodule

// File: rtl/control_sequencer_ring_counter.sv
// control_sequencer_ring_counter
//   T_COUNT-bit one-hot rotator.
//   clk     : rising-edge clock
//   rst     : synchronous active-high reset, loads T1
//   hold    : freeze the current state
//   t_state : one-hot state, bit 0 = T1
//   An illegal (non one-hot) state is forced back to T1 on the next edge,
//   even while hold is asserted, so the ring cannot stay stuck.
module control_sequencer_ring_counter
  import control_sequencer_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   hold,
  output t_vec_t t_state
);

  t_vec_t t_state_r;

  // Ring register: reset, recovery, hold or rotate left (T6 wraps to T1)
  always_ff @(posedge clk) begin
    if (rst) begin
      t_state_r <= T1;
    end else if (!is_one_hot(t_state_r)) begin
      t_state_r <= T1;
    end else if (hold) begin
      t_state_r <= t_state_r;
    end else begin
      t_state_r <= {t_state_r[T_COUNT-2:0], t_state_r[T_COUNT-1]};
    end
  end

  assign t_state = t_state_r;

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer
//   SAP-1 controller-sequencer: decodes the T-state and opcode into the
//   12-bit control word and holds the halt flag.
//   clk : rising-edge clock
//   rst : synchronous active-high reset (priority over halt)
//   bus : control_sequencer_if.master (opcode in; control_word, t_state,
//         halt out)
module control_sequencer
  import control_sequencer_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  control_sequencer_if.master bus
);

  t_vec_t t_state_s;
  logic   halt_r;
  logic   halt_set_s;
  logic   hold_s;
  cw_t    cw_s;

  // HLT is recognised on the edge that ends T4
  assign halt_set_s = (t_state_s == T4) && (bus.opcode == OP_HLT) && !halt_r;
  // Include halt_set_s so the ring does not step on the halting edge itself
  assign hold_s     = halt_r | halt_set_s;

  control_sequencer_ring_counter u_ring (
    .clk     (clk),
    .rst     (rst),
    .hold    (hold_s),
    .t_state (t_state_s)
  );

  // Halt flag: set by HLT in T4, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      halt_r <= 1'b0;
    end else if (halt_set_s) begin
      halt_r <= 1'b1;
    end else begin
      halt_r <= halt_r;
    end
  end

  // Control word decode; an illegal T-state falls into the default (no strobes)
  always_comb begin
    cw_s = CW_NONE;
    if (halt_r) begin
      cw_s = CW_NONE;
    end else begin
      case (t_state_s)
        T1: cw_s = CW_FETCH_T1;
        T2: cw_s = CW_FETCH_T2;
        T3: cw_s = CW_FETCH_T3;
        T4: begin
          case (bus.opcode)
            OP_LDA, OP_ADD, OP_SUB: cw_s = CW_IR_TO_MAR;
            OP_OUT:                 cw_s = CW_AR_TO_OUT;
            default:                cw_s = CW_NONE;
          endcase
        end
        T5: begin
          case (bus.opcode)
            OP_LDA:         cw_s = CW_MEM_TO_AR;
            OP_ADD, OP_SUB: cw_s = CW_MEM_TO_BR;
            default:        cw_s = CW_NONE;
          endcase
        end
        T6: begin
          case (bus.opcode)
            OP_ADD:  cw_s = CW_ALU_ADD;
            OP_SUB:  cw_s = CW_ALU_SUB;
            default: cw_s = CW_NONE;
          endcase
        end
        default: cw_s = CW_NONE;
      endcase
    end
  end

  assign bus.control_word = cw_s;
  assign bus.t_state      = t_state_s;
  assign bus.halt         = halt_r;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer
//   Directed self-checking bench for control_sequencer, followed by a
//   random opcode stream checked against a small control-word table.
module tb_control_sequencer;
  import control_sequencer_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  control_sequencer_if cs_if ();

  control_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (cs_if)
  );

  control_sequencer_chk u_chk (
    .clk          (clk),
    .rst          (rst),
    .control_word (cs_if.control_word),
    .t_state      (cs_if.t_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; inputs change and outputs are sampled on the falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Expected control word for ring index idx (0 = T1) and opcode op
  function automatic logic [11:0] model_cw(input int idx, input logic [3:0] op);
    logic [11:0] w;
    w = 12'h000;
    case (idx)
      0: w = 12'h600;
      1: w = 12'h800;
      2: w = 12'h180;
      3: begin
        case (op)
          4'h0, 4'h1, 4'h2: w = 12'h240;
          4'hE:             w = 12'h011;
          default:          w = 12'h000;
        endcase
      end
      4: begin
        case (op)
          4'h0:       w = 12'h120;
          4'h1, 4'h2: w = 12'h102;
          default:    w = 12'h000;
        endcase
      end
      5: begin
        case (op)
          4'h1:    w = 12'h024;
          4'h2:    w = 12'h02C;
          default: w = 12'h000;
        endcase
      end
      default: w = 12'h000;
    endcase
    return w;
  endfunction

  // Run one full instruction starting at T1; ends at the next T1
  task automatic run_instr(input string name, input logic [3:0] op,
                           input logic [11:0] w4, input logic [11:0] w5,
                           input logic [11:0] w6);
    logic [11:0] exp_w [6];
    exp_w[0] = 12'h600;
    exp_w[1] = 12'h800;
    exp_w[2] = 12'h180;
    exp_w[3] = w4;
    exp_w[4] = w5;
    exp_w[5] = w6;
    cs_if.opcode = op;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("%s_t%0d_state", name, i + 1), 32'(cs_if.t_state), 32'(6'd1 << i));
      check($sformatf("%s_t%0d_cw", name, i + 1), 32'(cs_if.control_word), 32'(exp_w[i]));
      check($sformatf("%s_t%0d_halt", name, i + 1), 32'(cs_if.halt), 32'd0);
      step();
    end
  endtask

  initial begin
    logic [3:0] rop;
    logic [11:0] cw;
    int idx;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    cs_if.opcode = 4'h0;
    @(negedge clk);
    step();
    step();
    rst = 1'b0;

    // Reset state
    check("reset_state", 32'(cs_if.t_state), 32'h01);
    check("reset_cw", 32'(cs_if.control_word), 32'h600);
    check("reset_halt", 32'(cs_if.halt), 32'd0);

    // LDA, then wrap to T1; ADD; SUB; OUT
    run_instr("lda", 4'h0, 12'h240, 12'h120, 12'h000);
    run_instr("add", 4'h1, 12'h240, 12'h102, 12'h024);
    run_instr("sub", 4'h2, 12'h240, 12'h102, 12'h02C);
    run_instr("out", 4'hE, 12'h011, 12'h000, 12'h000);

    // HLT: freezes in T4 with no strobes until reset
    cs_if.opcode = 4'hF;
    step(); step(); step();
    check("hlt_t4_state", 32'(cs_if.t_state), 32'h08);
    check("hlt_t4_cw", 32'(cs_if.control_word), 32'h000);
    check("hlt_t4_halt", 32'(cs_if.halt), 32'd0);
    step();
    for (int i = 0; i < 20; i++) begin
      if (i == 10) cs_if.opcode = 4'h1;  // opcode ignored while halted
      check($sformatf("halted_%0d_halt", i), 32'(cs_if.halt), 32'd1);
      check($sformatf("halted_%0d_state", i), 32'(cs_if.t_state), 32'h08);
      check($sformatf("halted_%0d_cw", i), 32'(cs_if.control_word), 32'h000);
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("unhalt_halt", 32'(cs_if.halt), 32'd0);
    check("unhalt_state", 32'(cs_if.t_state), 32'h01);
    check("unhalt_cw", 32'(cs_if.control_word), 32'h600);

    // Reset in T5 of ADD aborts the instruction before its LD_AR
    cs_if.opcode = 4'h1;
    step(); step(); step(); step();
    check("abort_t5_state", 32'(cs_if.t_state), 32'h10);
    check("abort_t5_cw", 32'(cs_if.control_word), 32'h102);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_state", 32'(cs_if.t_state), 32'h01);
    check("abort_cw", 32'(cs_if.control_word), 32'h600);
    check("abort_no_ld_ar", 32'(cs_if.control_word[CW_LD_AR]), 32'd0);

    // Undefined opcode behaves as NOP
    run_instr("nop5", 4'h5, 12'h000, 12'h000, 12'h000);

    // Random opcode stream (HLT excluded so the ring keeps running)
    idx = 0;
    for (int c = 0; c < 500; c++) begin
      rop = 4'($urandom_range(0, 14));
      cs_if.opcode = rop;
      #1;
      cw = cs_if.control_word;
      check($sformatf("rnd_%0d_cw", c), 32'(cw), 32'(model_cw(idx, rop)));
      check($sformatf("rnd_%0d_state", c), 32'(cs_if.t_state), 32'(6'd1 << idx));
      check($sformatf("rnd_%0d_one_driver", c),
            32'($onehot0({cw[10], cw[8], cw[6], cw[4], cw[2]})), 32'd1);
      check($sformatf("rnd_%0d_sub_alu", c), 32'(!cw[3] || cw[2]), 32'd1);
      step();
      idx = (idx + 1) % 6;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
